// File: rtl/fwd_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// fwd_hazard_ctrl_if
// Bundle between the ID stage and the forwarding/hazard controller.
//
// Signals:
//   id_valid               ID holds a real instruction
//   rs1_id, rs2_id         source register indices
//   use_rs1_id, use_rs2_id instruction actually reads rs1 / rs2
//   rd_id                  destination register index
//   reg_we_id              instruction writes rd
//   is_load_id             instruction is a load
//   hold                   global pipeline freeze (memory wait)
//   flush                  kill the instruction currently in ID
//   forward_data1/2        operand selects: 00 regfile, 01 EX, 10 MEM
//   stall_id               load-use stall request towards PC/IF/ID
//
// Handshake: there is no valid/ready pair here. id_valid qualifies the ID
// fields for the current cycle only; the controller answers combinationally
// in the same cycle and the pipeline obeys stall_id/hold at the next edge.
//
// Modports: master = ID stage side, slave = controller side.
// -----------------------------------------------------------------------------
interface fwd_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] rs1_id;
  logic [REG_ADDR_W-1:0] rs2_id;
  logic                  use_rs1_id;
  logic                  use_rs2_id;
  logic [REG_ADDR_W-1:0] rd_id;
  logic                  reg_we_id;
  logic                  is_load_id;
  logic                  hold;
  logic                  flush;
  logic [1:0]            forward_data1;
  logic [1:0]            forward_data2;
  logic                  stall_id;

  modport master (
    output id_valid, rs1_id, rs2_id, use_rs1_id, use_rs2_id,
           rd_id, reg_we_id, is_load_id, hold, flush,
    input  forward_data1, forward_data2, stall_id
  );

  modport slave (
    input  id_valid, rs1_id, rs2_id, use_rs1_id, use_rs2_id,
           rd_id, reg_we_id, is_load_id, hold, flush,
    output forward_data1, forward_data2, stall_id
  );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// fwd_hazard_ctrl
// Tracks the destination registers of the instructions in EX and MEM and
// produces the ID operand forward selects plus the load-use stall.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset, clears all tracked entries
//   bus    fwd_hazard_ctrl_if.slave (ID decode fields, hold/flush, outputs)
//   stall_cnt, fwd_ex_cnt, fwd_mem_cnt
//          performance counters, present only when FWD_PERF_CNT_EN is defined
//
// Parameters:
//   REG_ADDR_W  register index width
//   CNT_W       performance counter width (FWD_PERF_CNT_EN builds only)
//
// Optional feature macro: FWD_PERF_CNT_EN
// -----------------------------------------------------------------------------
module fwd_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fwd_hazard_ctrl_if.slave     bus
`ifdef FWD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     fwd_ex_cnt,
  output logic [CNT_W-1:0]     fwd_mem_cnt
`endif
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_EX  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("fwd_hazard_ctrl: CNT_W must be at least 1");
  end

  // EX slot
  logic                  v_ex;
  logic [REG_ADDR_W-1:0] rd_ex;
  logic                  we_ex;
  logic                  ld_ex;
  // MEM slot
  logic                  v_mem;
  logic [REG_ADDR_W-1:0] rd_mem;
  logic                  we_mem;

  logic match1_ex, match1_mem, match2_ex, match2_mem;
  logic haz1, haz2;
  logic stall;
  logic ex_take;

  always_comb begin
    match1_ex  = v_ex  & we_ex  & (rd_ex  == bus.rs1_id) & (bus.rs1_id != '0) & bus.use_rs1_id;
    match1_mem = v_mem & we_mem & (rd_mem == bus.rs1_id) & (bus.rs1_id != '0) & bus.use_rs1_id;
    match2_ex  = v_ex  & we_ex  & (rd_ex  == bus.rs2_id) & (bus.rs2_id != '0) & bus.use_rs2_id;
    match2_mem = v_mem & we_mem & (rd_mem == bus.rs2_id) & (bus.rs2_id != '0) & bus.use_rs2_id;

    // A load in EX has no data yet: the source reads the regfile this cycle
    // and any older MEM match is ignored, the stall cycle resolves it.
    haz1 = match1_ex & ld_ex;
    haz2 = match2_ex & ld_ex;

    bus.forward_data1 = SEL_RF;
    if (match1_ex & ~ld_ex)       bus.forward_data1 = SEL_EX;
    else if (match1_mem & ~haz1)  bus.forward_data1 = SEL_MEM;

    bus.forward_data2 = SEL_RF;
    if (match2_ex & ~ld_ex)       bus.forward_data2 = SEL_EX;
    else if (match2_mem & ~haz2)  bus.forward_data2 = SEL_MEM;

    // Flush beats the stall: the killed instruction needs no operands.
    stall        = bus.id_valid & ~bus.flush & (haz1 | haz2);
    bus.stall_id = stall;

    ex_take = bus.id_valid & ~bus.flush & ~stall;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_ex   <= 1'b0;
      rd_ex  <= '0;
      we_ex  <= 1'b0;
      ld_ex  <= 1'b0;
      v_mem  <= 1'b0;
      rd_mem <= '0;
      we_mem <= 1'b0;
    end else if (!bus.hold) begin
      v_mem  <= v_ex;
      rd_mem <= rd_ex;
      we_mem <= we_ex;
      if (ex_take) begin
        v_ex  <= 1'b1;
        rd_ex <= bus.rd_id;
        we_ex <= bus.reg_we_id;
        ld_ex <= bus.is_load_id;
      end else begin
        v_ex  <= 1'b0;
        rd_ex <= '0;
        we_ex <= 1'b0;
        ld_ex <= 1'b0;
      end
    end
  end

`ifdef FWD_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic any_ex_sel, any_mem_sel, fwd_qual;

  always_comb begin
    any_ex_sel  = (bus.forward_data1 == SEL_EX)  | (bus.forward_data2 == SEL_EX);
    any_mem_sel = (bus.forward_data1 == SEL_MEM) | (bus.forward_data2 == SEL_MEM);
    fwd_qual    = ~bus.hold & bus.id_valid & ~stall;
  end

  // Counters wrap naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt   <= '0;
      fwd_ex_cnt  <= '0;
      fwd_mem_cnt <= '0;
    end else begin
      if (stall & ~bus.hold)      stall_cnt   <= stall_cnt + CNT_ONE;
      if (fwd_qual & any_ex_sel)  fwd_ex_cnt  <= fwd_ex_cnt + CNT_ONE;
      if (fwd_qual & any_mem_sel) fwd_mem_cnt <= fwd_mem_cnt + CNT_ONE;
    end
  end
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fwd_hazard_ctrl
// Self-checking bench for fwd_hazard_ctrl. The reference model keeps the
// in-flight instructions as an age-ordered queue (index 0 = youngest) and
// resolves each source by searching for the youngest writer.
// -----------------------------------------------------------------------------
module tb_fwd_hazard_ctrl;

  localparam int RW = 5;
  localparam int CW = 32;

  typedef struct packed {
    logic          v;
    logic [RW-1:0] rd;
    logic          we;
    logic          ld;
  } slot_t;

  logic clk;
  logic rst_n;

  fwd_hazard_ctrl_if #(.REG_ADDR_W(RW)) intf ();

`ifdef FWD_PERF_CNT_EN
  logic [CW-1:0] stall_cnt, fwd_ex_cnt, fwd_mem_cnt;
`endif

  fwd_hazard_ctrl #(.REG_ADDR_W(RW), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (intf)
`ifdef FWD_PERF_CNT_EN
    ,
    .stall_cnt   (stall_cnt),
    .fwd_ex_cnt  (fwd_ex_cnt),
    .fwd_mem_cnt (fwd_mem_cnt)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model and scoreboard state ----------------
  slot_t       inflight[$];
  logic [CW-1:0] exp_stall_cnt, exp_ex_cnt, exp_mem_cnt;
  int vectors = 0;
  int errors  = 0;

  logic [1:0] e1, e2;
  logic       est;

  function automatic logic [1:0] model_sel(input logic [RW-1:0] s, input logic use_s,
                                           output logic haz);
    logic [1:0] sel;
    sel = 2'b00;
    haz = 1'b0;
    if (use_s && s != 0) begin
      for (int age = 0; age < 2; age++) begin
        if (inflight[age].v && inflight[age].we && inflight[age].rd == s) begin
          if (age == 0 && inflight[age].ld) haz = 1'b1;
          else sel = (age == 0) ? 2'b01 : 2'b10;
          break;
        end
      end
    end
    return sel;
  endfunction

  task automatic model_eval();
    logic h1, h2;
    e1  = model_sel(intf.rs1_id, intf.use_rs1_id, h1);
    e2  = model_sel(intf.rs2_id, intf.use_rs2_id, h2);
    est = intf.id_valid && !intf.flush && (h1 || h2);
  endtask

  task automatic model_clear();
    inflight.delete();
    inflight.push_back('0);
    inflight.push_back('0);
    exp_stall_cnt = '0;
    exp_ex_cnt    = '0;
    exp_mem_cnt   = '0;
  endtask

  // Advance one clock: the model ages its queue unless the pipe is held.
  task automatic tick();
    slot_t nw;
    model_eval();
    if (!intf.hold) begin
      if (est) exp_stall_cnt++;
      if (intf.id_valid && !est && (e1 == 2'b01 || e2 == 2'b01)) exp_ex_cnt++;
      if (intf.id_valid && !est && (e1 == 2'b10 || e2 == 2'b10)) exp_mem_cnt++;
    end
    if (intf.id_valid && !intf.flush && !est)
      nw = {1'b1, intf.rd_id, intf.reg_we_id, intf.is_load_id};
    else
      nw = '0;
    @(posedge clk);
    if (!intf.hold) begin
      inflight.push_front(nw);
      void'(inflight.pop_back());
    end
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_id(input logic v, input logic [RW-1:0] r1, input logic [RW-1:0] r2,
                        input logic u1, input logic u2, input logic [RW-1:0] rd,
                        input logic we, input logic ld);
    intf.id_valid   = v;
    intf.rs1_id     = r1;
    intf.rs2_id     = r2;
    intf.use_rs1_id = u1;
    intf.use_rs2_id = u2;
    intf.rd_id      = rd;
    intf.reg_we_id  = we;
    intf.is_load_id = ld;
  endtask

  task automatic set_ctl(input logic h, input logic f);
    intf.hold  = h;
    intf.flush = f;
  endtask

  task automatic do_reset();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    set_ctl(0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    set_id(1, 3, 4, 1, 1, 5, 1, 1);
    set_ctl(0, 0);
    @(negedge clk);
    vectors++;
    if (intf.forward_data1 !== 2'b00 || intf.forward_data2 !== 2'b00 || intf.stall_id !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got f1=%b f2=%b st=%b, want 00 00 0",
               intf.forward_data1, intf.forward_data2, intf.stall_id);
    end
    do_reset();
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_id(1, 0, 0, 0, 0, 5, 1, 0);           // addi x5
    tick();
    set_id(1, 5, 0, 1, 0, 0, 0, 0);           // non-writing reader of x5
    @(negedge clk);
    vectors++;
    if (intf.forward_data1 !== 2'b01 || intf.stall_id !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ex: got f1=%b st=%b, want 01 0", intf.forward_data1, intf.stall_id);
    end
    tick();
    set_id(1, 0, 5, 0, 1, 7, 1, 0);           // reads x5 as rs2
    @(negedge clk);
    vectors++;
    if (intf.forward_data2 !== 2'b10 || intf.forward_data1 !== 2'b00 || intf.stall_id !== 1'b0) begin
      errors++;
      $display("FAIL b2b_mem: got f1=%b f2=%b st=%b, want 00 10 0",
               intf.forward_data1, intf.forward_data2, intf.stall_id);
    end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    set_id(1, 1, 0, 1, 0, 7, 1, 1);           // lw x7
    tick();
    set_id(1, 7, 7, 1, 1, 8, 1, 0);           // add x8,x7,x7
    @(negedge clk);
    vectors++;
    if (intf.stall_id !== 1'b1 || intf.forward_data1 !== 2'b00 || intf.forward_data2 !== 2'b00) begin
      errors++;
      $display("FAIL load_use_stall: got f1=%b f2=%b st=%b, want 00 00 1",
               intf.forward_data1, intf.forward_data2, intf.stall_id);
    end
    tick();
    @(negedge clk);
    vectors++;
    if (intf.stall_id !== 1'b0 || intf.forward_data1 !== 2'b10 || intf.forward_data2 !== 2'b10) begin
      errors++;
      $display("FAIL load_use_resolve: got f1=%b f2=%b st=%b, want 10 10 0",
               intf.forward_data1, intf.forward_data2, intf.stall_id);
    end
    tick();
  endtask

  task automatic test_priority();
    do_reset();
    set_id(1, 0, 0, 0, 0, 3, 1, 0);
    tick();
    set_id(1, 0, 0, 0, 0, 3, 1, 0);
    tick();
    set_id(1, 3, 0, 1, 0, 0, 0, 0);
    @(negedge clk);
    vectors++;
    if (intf.forward_data1 !== 2'b01) begin
      errors++;
      $display("FAIL ex_over_mem: got f1=%b, want 01", intf.forward_data1);
    end
    do_reset();
    set_id(1, 0, 0, 0, 0, 0, 1, 0);           // writes x0
    tick();
    set_id(1, 0, 0, 0, 0, 0, 1, 1);           // load into x0
    tick();
    set_id(1, 0, 0, 1, 1, 2, 1, 0);
    @(negedge clk);
    vectors++;
    if (intf.forward_data1 !== 2'b00 || intf.forward_data2 !== 2'b00 || intf.stall_id !== 1'b0) begin
      errors++;
      $display("FAIL x0_source: got f1=%b f2=%b st=%b, want 00 00 0",
               intf.forward_data1, intf.forward_data2, intf.stall_id);
    end
    tick();
  endtask

  task automatic test_flush();
    do_reset();
    set_id(1, 0, 0, 0, 0, 9, 1, 1);           // lw x9
    tick();
    set_id(1, 9, 0, 1, 0, 10, 1, 0);
    set_ctl(0, 1);
    @(negedge clk);
    vectors++;
    if (intf.stall_id !== 1'b0) begin
      errors++;
      $display("FAIL flush_over_stall: got st=%b, want 0", intf.stall_id);
    end
    tick();
    set_ctl(0, 0);
    set_id(1, 9, 9, 1, 1, 11, 1, 0);          // EX must be a bubble, MEM has x9
    @(negedge clk);
    vectors++;
    if (intf.forward_data1 !== 2'b10 || intf.forward_data2 !== 2'b10 || intf.stall_id !== 1'b0) begin
      errors++;
      $display("FAIL flush_bubble: got f1=%b f2=%b st=%b, want 10 10 0",
               intf.forward_data1, intf.forward_data2, intf.stall_id);
    end
    tick();
  endtask

  task automatic test_hold();
    do_reset();
    set_id(1, 0, 0, 0, 0, 4, 1, 1);           // lw x4
    tick();
    set_id(1, 4, 2, 1, 1, 12, 1, 0);
    set_ctl(1, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++;
      if (intf.stall_id !== 1'b1 || intf.forward_data1 !== 2'b00) begin
        errors++;
        $display("FAIL hold_stall[%0d]: got f1=%b st=%b, want 00 1", c, intf.forward_data1, intf.stall_id);
      end
      tick();
    end
    set_ctl(0, 0);
    @(negedge clk);
    vectors++;
    if (intf.stall_id !== 1'b1) begin
      errors++;
      $display("FAIL hold_release_stall: got st=%b, want 1", intf.stall_id);
    end
    tick();
    @(negedge clk);
    vectors++;
    if (intf.stall_id !== 1'b0 || intf.forward_data1 !== 2'b10) begin
      errors++;
      $display("FAIL hold_resolve: got f1=%b st=%b, want 10 0", intf.forward_data1, intf.stall_id);
    end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      set_id($urandom_range(0, 9) != 0,
             RW'($urandom_range(0, 7)), RW'($urandom_range(0, 7)),
             $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
             RW'($urandom_range(0, 7)), $urandom_range(0, 4) != 0,
             $urandom_range(0, 2) == 0);
      set_ctl($urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
      @(negedge clk);
      model_eval();
      vectors++;
      if (intf.forward_data1 !== e1 || intf.forward_data2 !== e2 || intf.stall_id !== est) begin
        errors++;
        $display("FAIL random[%0d]: got f1=%b f2=%b st=%b, want %b %b %b",
                 n, intf.forward_data1, intf.forward_data2, intf.stall_id, e1, e2, est);
      end
      tick();
    end
`ifdef FWD_PERF_CNT_EN
    vectors++;
    if (stall_cnt !== exp_stall_cnt || fwd_ex_cnt !== exp_ex_cnt || fwd_mem_cnt !== exp_mem_cnt) begin
      errors++;
      $display("FAIL perf_counters: got %0d %0d %0d, want %0d %0d %0d",
               stall_cnt, fwd_ex_cnt, fwd_mem_cnt, exp_stall_cnt, exp_ex_cnt, exp_mem_cnt);
    end
`endif
  endtask

  task automatic test_async_reset();
    do_reset();
    set_id(1, 0, 0, 0, 0, 6, 1, 1);           // lw x6
    tick();
    set_id(1, 6, 6, 1, 1, 13, 1, 0);
    @(negedge clk);
    vectors++;
    if (intf.stall_id !== 1'b1) begin
      errors++;
      $display("FAIL async_pre: got st=%b, want 1", intf.stall_id);
    end
    #2;
    rst_n = 1'b0;                             // between edges
    #1;
    vectors++;
    if (intf.forward_data1 !== 2'b00 || intf.forward_data2 !== 2'b00 || intf.stall_id !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got f1=%b f2=%b st=%b, want 00 00 0",
               intf.forward_data1, intf.forward_data2, intf.stall_id);
    end
`ifdef FWD_PERF_CNT_EN
    vectors++;
    if (stall_cnt !== '0 || fwd_ex_cnt !== '0 || fwd_mem_cnt !== '0) begin
      errors++;
      $display("FAIL async_reset_cnt: got %0d %0d %0d, want 0 0 0", stall_cnt, fwd_ex_cnt, fwd_mem_cnt);
    end
`endif
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_n = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    set_ctl(0, 0);
    model_clear();
    test_reset();
    test_back_to_back();
    test_load_use();
    test_priority();
    test_flush();
    test_hold();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
